// File: rtl/hls_mem_responder_pkg.sv
// Shared widths, defaults and helpers for the HLS memory responder.
package hls_mem_pkg;

  localparam int DATA_W        = 32;
  localparam int ADDR_W        = 32;
  localparam int CNT_W         = 16;
  localparam int DEPTH_DEFAULT = 256;
  localparam int RD_LAT_MAX    = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hls_mem_responder_if.sv
// HLS ap_memory style access port: address/enable/write toward memory, read data back.
interface hls_mem_if;
  import hls_mem_pkg::*;

  addr_t address0;
  logic  ce0;
  logic  we0;
  data_t d0;
  data_t q0;
  logic  q0_valid;

  modport master (output address0, ce0, we0, d0, input q0, q0_valid);
  modport slave  (input address0, ce0, we0, d0, output q0, q0_valid);

endinterface

// File: rtl/hls_mem_responder_rd_pipe.sv
// Delays a {valid, data} read result by RD_LAT register stages; data stages load only
// on valid so the last stage holds the most recent read result.
module mem_rd_pipe
  import hls_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  rd_valid,
  input  data_t rd_data,
  output logic  q_valid,
  output data_t q_data
);

  logic [RD_LAT-1:0] vld;
  data_t             dat [RD_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= rd_valid;
      if (rd_valid) dat[0] <= rd_data;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign q_valid = vld[RD_LAT-1];
  assign q_data  = dat[RD_LAT-1];

endmodule

// File: rtl/hls_mem_responder.sv
// Word memory answering an HLS memory port, with preload path, sticky error flags
// and saturating access counters.
module hls_mem_responder
  import hls_mem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int RD_LAT = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  hls_mem_if.slave   bus,
  input  logic       init_en,
  input  addr_t      init_addr,
  input  data_t      init_data,
  input  logic       clear,
  output logic       err_oob,
  output logic       err_collide,
  output addr_t      err_addr,
  output cnt_t       rd_count,
  output cnt_t       wr_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  data_t mem [DEPTH];

  logic  in_range, init_in_range;
  logic  access, rd_acc, wr_acc, oob_hit;
  data_t rd_data;
  cnt_t  rd_base, wr_base;
  logic  oob_base, col_base;
  addr_t addr_base;

  // A preload in the same cycle wins the port; the initiator's access is dropped.
  assign in_range      = bus.address0 < ADDR_W'(DEPTH);
  assign init_in_range = init_addr < ADDR_W'(DEPTH);
  assign access        = bus.ce0 & ~init_en;
  assign rd_acc        = access & ~bus.we0;
  assign wr_acc        = access & bus.we0;
  assign oob_hit       = access & ~in_range;
  assign rd_data       = in_range ? mem[bus.address0[IDX_W-1:0]] : '0;

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      if (init_en && init_in_range)
        mem[init_addr[IDX_W-1:0]] <= init_data;
      else if (wr_acc && in_range)
        mem[bus.address0[IDX_W-1:0]] <= bus.d0;
    end
  end

  // Clear zeroes the status first so an event in the same cycle still lands.
  always_comb begin
    rd_base   = clear ? '0 : rd_count;
    wr_base   = clear ? '0 : wr_count;
    oob_base  = clear ? 1'b0 : err_oob;
    col_base  = clear ? 1'b0 : err_collide;
    addr_base = clear ? '0 : err_addr;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rd_count    <= '0;
      wr_count    <= '0;
      err_oob     <= 1'b0;
      err_collide <= 1'b0;
      err_addr    <= '0;
    end else begin
      rd_count    <= rd_acc ? sat_inc(rd_base) : rd_base;
      wr_count    <= wr_acc ? sat_inc(wr_base) : wr_base;
      err_oob     <= oob_base | oob_hit;
      err_collide <= col_base | (init_en & bus.ce0);
      err_addr    <= (oob_hit && !oob_base) ? bus.address0 : addr_base;
    end
  end

  mem_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .rd_valid (rd_acc),
    .rd_data  (rd_data),
    .q_valid  (bus.q0_valid),
    .q_data   (bus.q0)
  );

endmodule

// File: doc/hls_mem_responder.md
HLS_MEM_RESPONDER -- requirements
Module: hls_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words stored.
REQ-002 SHALL have parameter RD_LAT, default 1, meaning read latency in cycles; legal range 1..4.
REQ-003 SHALL have port sys_clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1, synchronous active-low reset, sampled on the sys_clk rising edge.
REQ-005 SHALL have port address0, input, 32, word address from the initiator.
REQ-006 SHALL have port ce0, input, 1, access enable.
REQ-007 SHALL have port we0, input, 1, write enable, qualified by ce0.
REQ-008 SHALL have port d0, input, 32, write data.
REQ-009 SHALL have port q0, output, 32, read data.
REQ-010 SHALL have port q0_valid, output, 1, one-cycle pulse marking a read result on q0.
REQ-011 SHALL have port init_en, input, 1, preload strobe.
REQ-012 SHALL have port init_addr, input, 32, preload address.
REQ-013 SHALL have port init_data, input, 32, preload data.
REQ-014 SHALL have port clear, input, 1, clears the sticky flags and counters.
REQ-015 SHALL have port err_oob, output, 1, sticky out-of-range access flag.
REQ-016 SHALL have port err_collide, output, 1, sticky flag for init_en and ce0 in the same cycle.
REQ-017 SHALL have port err_addr, output, 32, address of the first out-of-range access since the last clear or reset.
REQ-018 SHALL have port rd_count, output, 16, number of accepted reads.
REQ-019 SHALL have port wr_count, output, 16, number of accepted writes.

Function
REQ-020 Read (ce0=1, we0=0, address0<DEPTH, init_en=0) sampled at edge N SHALL drive q0=mem[address0] with q0_valid=1 for exactly the cycle following edge N+RD_LAT-1; with RD_LAT=1 this is the cycle after edge N.
REQ-021 q0 SHALL hold its last read value until the next read result arrives; it SHALL NOT change on writes or idle cycles.
REQ-022 Reads SHALL be fully pipelined: one read per cycle is accepted, and results return in issue order.
REQ-023 Write (ce0=1, we0=1, address0<DEPTH, init_en=0) SHALL update mem[address0]=d0 at that edge; q0_valid SHALL stay 0 for the write.
REQ-024 A read issued in the cycle after a write to the same address SHALL return the newly written data.
REQ-025 Out-of-range access (address0>=DEPTH):
- write discarded;
- read still produces a q0_valid pulse with q0=0;
- err_oob set;
- err_addr captured only if err_oob was 0.
REQ-026 init_en=1 SHALL write mem[init_addr]=init_data when init_addr<DEPTH and be ignored otherwise; init accesses SHALL NOT touch the counters, err_oob or err_addr.
REQ-027 init_en=1 together with ce0=1 SHALL drop the ce0 access (no write, no q0_valid, not counted) and set err_collide.
REQ-028 rd_count and wr_count SHALL increment per accepted in-range or out-of-range access and saturate at 16'hFFFF.
REQ-029 clear=1 SHALL zero the counters, err_oob, err_collide and err_addr at that edge; an event in the same cycle SHALL apply after the clear, so that cycle ends with count=1 and/or flag=1.
REQ-030 The read pipeline SHALL continue to drain while clear is asserted.

Reset
REQ-031 On sys_rst_n=0 at an edge: q0=0, q0_valid=0, err_oob=0, err_collide=0, err_addr=0, rd_count=0, wr_count=0.
REQ-032 Reset SHALL flush the read pipeline, so no q0_valid pulse is emitted for reads issued before or during reset.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 Accesses presented while sys_rst_n=0 SHALL be ignored.

Structure
REQ-035 Package hls_mem_pkg SHALL hold DATA_W=32, ADDR_W=32, CNT_W=16, DEPTH_DEFAULT=256 and RD_LAT_MAX=4.
REQ-036 Read-latency delay of the {valid, data} pair SHALL be a sub-module mem_rd_pipe, parameterised by RD_LAT, with synchronous active-low reset.

Verification
REQ-037 Preload mem[5]=32'hDEADBEEF via init, then read address 5 with RD_LAT=1 -> q0=32'hDEADBEEF, q0_valid high for one cycle at edge+1, rd_count=1.
REQ-038 RD_LAT=3; back-to-back reads of addresses 0,1,2 holding 10,11,12 -> q0_valid for 3 consecutive cycles starting 3 cycles after the first read, data 10,11,12.
REQ-039 Write address 7=32'h00000055, then read address 7 the next cycle -> q0=32'h55, wr_count=1, rd_count=1.
REQ-040 Read address 300, then write address 400 (DEPTH=256) -> q0=0 with q0_valid pulse, err_oob=1, err_addr=300, wr_count=1; reading address 144 afterwards shows it is unchanged.
REQ-041 init_en and ce0 write in the same cycle -> only the init data is stored, err_collide=1, wr_count unchanged; clear plus a read in the same cycle -> err_collide=0, rd_count=1.
REQ-042 Issue a read with RD_LAT=2, assert sys_rst_n=0 for one cycle on the next edge -> no q0_valid pulse, all outputs 0.
